// File: rtl/mcpu5_pkg.sv
// Shared types and opcode constants for the MCPU5 pad-level host driver.
package mcpu5_pkg;

    localparam int unsigned INST_W = 6;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RST_LO,
        RST_HI,
        RUN_LO,
        RUN_HI,
        HALT
    } state_e;

    localparam logic [INST_W-1:0] OP_OUT = 6'b111001;
    localparam logic [INST_W-1:0] OP_NOP = 6'b111011;
    localparam logic [INST_W-1:0] OP_NOT = 6'b111000;
    localparam logic [1:0]        OP_LDI = 2'b01;
    localparam logic [1:0]        OP_BCC = 2'b00;

endpackage

// File: rtl/mcpu5_host_prog_ram.sv
// 64x6 program store: synchronous write, asynchronous read.
module mcpu5_host_prog_ram
    import mcpu5_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [INST_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [INST_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [INST_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mcpu5_host.sv
// Host driver for the MCPU5 pad interface: CPU clock/reset generation, program serving, OUT capture.
// Optional breakpoint support is compiled in with `define MCPU5_HOST_BRK_EN.
module mcpu5_host
    import mcpu5_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [7:0]        cpu_io_in_o,
    input  logic [7:0]        cpu_io_out_i,
    input  logic              prog_we,
    input  logic [5:0]        prog_addr,
    input  logic [5:0]        prog_data,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
`ifdef MCPU5_HOST_BRK_EN
    input  logic              bp_en,
    input  logic [5:0]        bp_addr,
    output logic              brk_hit,
`endif
    output logic              running,
    output logic [5:0]        pc_o,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int unsigned TMR_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLK_DIV - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic                cpu_clk_q, cpu_clk_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                stop_pend_q, stop_pend_d;
    logic                step_mode_q, step_mode_d;
    logic                running_q, running_d;

    logic                phase_last;
    logic                stop_any;
    logic                brk_now;
    logic                go_run;
    logic                go_halt;
    logic [ADDR_W-1:0]   ram_raddr;
    logic [INST_W-1:0]   ram_rdata;
    logic                ram_we;

    assign phase_last = (tmr_q == TMR_LAST);
    assign stop_any   = stop_pend_q | stop;
    assign ram_we     = prog_we && (state_q == IDLE || state_q == HALT);
    // Entries into RUN_LO from a sampling phase must fetch at the freshly sampled pc
    assign ram_raddr  = (state_q == RST_HI || state_q == RUN_HI) ? cpu_io_out_i[5:0] : pc_q;

`ifdef MCPU5_HOST_BRK_EN
    assign brk_now = bp_en && (cpu_io_out_i[5:0] == bp_addr);
`else
    assign brk_now = 1'b0;
`endif

    mcpu5_host_prog_ram u_prog_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Next-state and phase-output logic
    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        cpu_clk_d   = cpu_clk_q;
        cpu_rst_d   = cpu_rst_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q | (stop & running_q);
        step_mode_d = step_mode_q;
        running_d   = running_q;
        go_run      = 1'b0;
        go_halt     = 1'b0;

        if (state_q == IDLE || state_q == HALT || phase_last) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d     = RST_LO;
                    cpu_clk_d   = 1'b0;
                    cpu_rst_d   = 1'b1;
                    rcnt_d      = '0;
                    stop_pend_d = 1'b0;
                    running_d   = 1'b1;
                end
            end
            RST_LO: begin
                if (phase_last) begin
                    state_d   = RST_HI;
                    cpu_clk_d = 1'b1;
                end
            end
            RST_HI: begin
                if (phase_last) begin
                    if (rcnt_q == RCNT_LAST) begin
                        pc_d = cpu_io_out_i[5:0];
                        if (stop_any) begin
                            go_halt = 1'b1;
                        end else begin
                            go_run = 1'b1;
                        end
                    end else begin
                        rcnt_d    = rcnt_q + RCNT_W'(1);
                        state_d   = RST_LO;
                        cpu_clk_d = 1'b0;
                    end
                end
            end
            RUN_LO: begin
                if (phase_last) begin
                    if (inst_q == OP_OUT) begin
                        out_data_d  = cpu_io_out_i;
                        out_valid_d = 1'b1;
                    end
                    state_d   = RUN_HI;
                    cpu_clk_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN_HI: begin
                if (phase_last) begin
                    pc_d = cpu_io_out_i[5:0];
                    if (stop_any || step_mode_q || brk_now) begin
                        go_halt = 1'b1;
                    end else begin
                        go_run = 1'b1;
                    end
                end
            end
            HALT: begin
                if (stop) begin
                    state_d = HALT;
                end else if (start) begin
                    go_run      = 1'b1;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    go_run      = 1'b1;
                    step_mode_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_run) begin
            state_d   = RUN_LO;
            cpu_clk_d = 1'b0;
            cpu_rst_d = 1'b0;
            inst_d    = ram_rdata;
            running_d = 1'b1;
        end
        if (go_halt) begin
            state_d     = HALT;
            cpu_clk_d   = 1'b0;
            cpu_rst_d   = 1'b0;
            inst_d      = OP_NOP;
            stop_pend_d = 1'b0;
            step_mode_d = 1'b0;
            running_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            rcnt_q      <= '0;
            cpu_clk_q   <= 1'b0;
            cpu_rst_q   <= 1'b1;
            inst_q      <= OP_NOP;
            pc_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            step_mode_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            rcnt_q      <= rcnt_d;
            cpu_clk_q   <= cpu_clk_d;
            cpu_rst_q   <= cpu_rst_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            step_mode_q <= step_mode_d;
            running_q   <= running_d;
        end
    end

`ifdef MCPU5_HOST_BRK_EN
    logic brk_hit_q, brk_hit_d;

    // Sticky breakpoint flag; a new hit takes priority over a same-cycle clear
    always_comb begin
        brk_hit_d = brk_hit_q;
        if (start || step) begin
            brk_hit_d = 1'b0;
        end
        if (state_q == RUN_HI && phase_last && brk_now) begin
            brk_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk_hit_q <= 1'b0;
        end else begin
            brk_hit_q <= brk_hit_d;
        end
    end

    assign brk_hit = brk_hit_q;
`endif

    assign cpu_io_in_o = {inst_q, cpu_rst_q, cpu_clk_q};
    assign running     = running_q;
    assign pc_o        = pc_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign cycle_cnt   = cnt_q;

endmodule
